// File: rtl/timer_pkg.sv
// Shared types and default widths for the timer counter sequencing controller.
package timer_pkg;

   localparam int DIV_W_DEF = 8;
   localparam int CNT_W_DEF = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

endpackage

// File: rtl/timer_cnt_ctrl_if.sv
// Regset/counter/debug signal bundle between timer_cnt_ctrl and its neighbours.
interface timer_cnt_ctrl_if #(
   parameter int DIV_W = timer_pkg::DIV_W_DEF,
   parameter int CNT_W = timer_pkg::CNT_W_DEF
) ();
   import timer_pkg::*;

   logic             timer_en;
   logic             div_en;
   logic [DIV_W-1:0] div_val;
   logic             halt_req;
   logic [CNT_W-1:0] cmp_val;
   logic             int_en;
   logic             int_st_clr;
   logic [CNT_W-1:0] count;
   logic             count_en;
   logic             halt_ack;
   logic             int_st;
   logic             interrupt;

   // master: regset + counter + debug side
   modport master (
      output timer_en, div_en, div_val, halt_req, cmp_val, int_en, int_st_clr, count,
      input  count_en, halt_ack, int_st, interrupt
   );

   modport slave (
      input  timer_en, div_en, div_val, halt_req, cmp_val, int_en, int_st_clr, count,
      output count_en, halt_ack, int_st, interrupt
   );

endinterface

// File: rtl/timer_prescaler.sv
// Programmable prescaler: divides RUN cycles by div_val+1 and flags the terminal count.
module timer_prescaler #(
   parameter int DIV_W = timer_pkg::DIV_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             freeze,
   input  logic             div_en,
   input  logic [DIV_W-1:0] div_val,
   output logic             tick
);
   import timer_pkg::*;

   logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [DIV_W-1:0] div_val_q, div_val_d;
   logic             term;

   assign term = (pre_cnt_q == div_val);

   always_comb begin
      div_val_d = div_val;
      pre_cnt_d = pre_cnt_q;
      if (freeze)
         pre_cnt_d = pre_cnt_q;
      else if (!run || !div_en || term)
         pre_cnt_d = '0;
      else
         pre_cnt_d = pre_cnt_q + 1'b1;
      // A new divisor restarts the period so pre_cnt can never sit above div_val.
      if (div_en && (div_val != div_val_q))
         pre_cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_q <= '0;
         div_val_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
         div_val_q <= div_val_d;
      end
   end

   assign tick = run & (~div_en | term);

endmodule

// File: rtl/timer_cnt_ctrl.sv
// Timer run/halt FSM, prescaled count strobe and sticky compare interrupt.
// Define TIMER_HALT_EN to build the debug HALT state and halt_req/halt_ack handshake.
module timer_cnt_ctrl #(
   parameter int DIV_W = timer_pkg::DIV_W_DEF,
   parameter int CNT_W = timer_pkg::CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   timer_cnt_ctrl_if.slave   bus
);
   import timer_pkg::*;

   state_e state_q, state_d;
   logic   halt_ack_q, halt_ack_d;
   logic   int_st_q, int_st_d;
   logic   match;
   logic   tick;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.timer_en) state_d = ST_RUN;
         ST_RUN: begin
            if (!bus.timer_en)
               state_d = ST_IDLE;
`ifdef TIMER_HALT_EN
            else if (bus.halt_req)
               state_d = ST_HALT;
`endif
         end
`ifdef TIMER_HALT_EN
         // Disable beats halt handling so a halted timer can always be stopped.
         ST_HALT: begin
            if (!bus.timer_en)
               state_d = ST_IDLE;
            else if (!bus.halt_req)
               state_d = ST_RUN;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef TIMER_HALT_EN
   assign halt_ack_d = (state_d == ST_HALT);
`else
   logic unused_halt_req;
   assign unused_halt_req = bus.halt_req;
   assign halt_ack_d      = 1'b0;
`endif

   // Matches on any count source, including regset loads; set beats clear.
   assign match    = bus.timer_en & (bus.count == bus.cmp_val);
   assign int_st_d = match ? 1'b1 : (bus.int_st_clr ? 1'b0 : int_st_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         halt_ack_q <= 1'b0;
         int_st_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         halt_ack_q <= halt_ack_d;
         int_st_q   <= int_st_d;
      end
   end

   timer_prescaler #(.DIV_W(DIV_W)) u_pre (
      .clk     (clk),
      .reset   (reset),
      .run     (state_q == ST_RUN),
      .freeze  (state_q == ST_HALT),
      .div_en  (bus.div_en),
      .div_val (bus.div_val),
      .tick    (tick)
   );

   assign bus.count_en  = tick;
   assign bus.halt_ack  = halt_ack_q;
   assign bus.int_st    = int_st_q;
   assign bus.interrupt = int_st_q & bus.int_en;

   a_no_tick_off_run: assert property (@(posedge clk) disable iff (reset)
      (state_q != ST_RUN) |-> !bus.count_en);
   a_ack_is_halt: assert property (@(posedge clk) disable iff (reset)
      bus.halt_ack == (state_q == ST_HALT));

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Scoreboard bench for timer_cnt_ctrl: expected count_en pulse cycles and int_st rise cycles are queued.
module tb_timer_cnt_ctrl;

   logic        clk;
   logic        reset;
   logic        ld;
   logic [63:0] ld_val;
   logic [63:0] cnt;
   int          cyc;
   int          n_chk;
   int          n_err;
   bit          chk_pulse;
   int          pulse_q[$];
   int          int_q[$];

   timer_cnt_ctrl_if #(.DIV_W(8), .CNT_W(64)) ifc ();

   timer_cnt_ctrl #(.DIV_W(8), .CNT_W(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // counter datapath model
   always @(posedge clk) begin
      if (ld)                cnt <= ld_val;
      else if (ifc.count_en) cnt <= cnt + 64'd1;
   end
   assign ifc.count = cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // monitor: pops expected event cycles when the DUT presents a strobe/rise
   initial begin
      logic prev_int;
      int   e;
      prev_int = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_pulse && ifc.count_en === 1'b1) begin
            e = (pulse_q.size() != 0) ? pulse_q.pop_front() : -1;
            check("count_en_cycle", 64'(cyc), 64'(e));
         end
         if (ifc.int_st === 1'b1 && prev_int !== 1'b1) begin
            e = (int_q.size() != 0) ? int_q.pop_front() : -1;
            check("int_st_rise_cycle", 64'(cyc), 64'(e));
         end
         prev_int = ifc.int_st;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      n_chk = 0; n_err = 0; cyc = 0; chk_pulse = 0;
      reset = 1'b1; ld = 1'b1; ld_val = 64'd0;
      ifc.timer_en = 0; ifc.div_en = 0; ifc.div_val = 8'd0; ifc.halt_req = 0;
      ifc.cmp_val = 64'hDEAD_BEEF_0000_0000; ifc.int_en = 1; ifc.int_st_clr = 0;
      wait_cyc(3);
      check("rst_count_en", {63'd0, ifc.count_en}, 64'd0);
      check("rst_halt_ack", {63'd0, ifc.halt_ack}, 64'd0);
      check("rst_int_st", {63'd0, ifc.int_st}, 64'd0);
      check("rst_interrupt", {63'd0, ifc.interrupt}, 64'd0);
      reset = 1'b0; ld = 1'b0;
      wait_cyc(5);

      // undivided counting: count 0 -> 10 in 10 cycles
      chk_pulse = 1;
      c0 = cyc;
      ifc.timer_en = 1;
      for (int k = 1; k <= 10; k++) pulse_q.push_back(c0 + k);
      wait_cyc(c0 + 10);
      ifc.timer_en = 0;
      wait_cyc(c0 + 11);
      check("count_after_10", cnt, 64'd10);
      wait_cyc(c0 + 13);
      check("t1_pulses_left", 64'(pulse_q.size()), 64'd0);

      // divide by 4, then switch to divide by 2 mid-period
      ifc.div_en = 1; ifc.div_val = 8'd3;
      wait_cyc(cyc + 2);
      c0 = cyc;
      ifc.timer_en = 1;
      pulse_q.push_back(c0 + 4);  pulse_q.push_back(c0 + 8);  pulse_q.push_back(c0 + 12);
      pulse_q.push_back(c0 + 17); pulse_q.push_back(c0 + 19); pulse_q.push_back(c0 + 21);
      wait_cyc(c0 + 15);
      ifc.div_val = 8'd1;
      wait_cyc(c0 + 21);
      ifc.timer_en = 0;
      wait_cyc(c0 + 23);
      check("t2_pulses_left", 64'(pulse_q.size()), 64'd0);

      // halt for 5 cycles with pre_cnt frozen at 2
      ifc.div_val = 8'd3;
      wait_cyc(cyc + 2);
      c0 = cyc;
      ifc.timer_en = 1;
`ifdef TIMER_HALT_EN
      pulse_q.push_back(c0 + 4); pulse_q.push_back(c0 + 13); pulse_q.push_back(c0 + 17);
`else
      pulse_q.push_back(c0 + 4);  pulse_q.push_back(c0 + 8);
      pulse_q.push_back(c0 + 12); pulse_q.push_back(c0 + 16);
`endif
      wait_cyc(c0 + 6);
      ifc.halt_req = 1;
      wait_cyc(c0 + 8);
`ifdef TIMER_HALT_EN
      check("halt_ack_in_halt", {63'd0, ifc.halt_ack}, 64'd1);
`else
      check("halt_ack_unbuilt", {63'd0, ifc.halt_ack}, 64'd0);
`endif
      wait_cyc(c0 + 11);
      ifc.halt_req = 0;
`ifdef TIMER_HALT_EN
      check("halt_ack_last", {63'd0, ifc.halt_ack}, 64'd1);
`else
      check("halt_ack_unbuilt2", {63'd0, ifc.halt_ack}, 64'd0);
`endif
      wait_cyc(c0 + 12);
      check("halt_ack_released", {63'd0, ifc.halt_ack}, 64'd0);
      wait_cyc(c0 + 17);
      ifc.timer_en = 0;
      wait_cyc(c0 + 19);
      check("t3_pulses_left", 64'(pulse_q.size()), 64'd0);
      chk_pulse = 0;

      // compare match, clear, and clear coincident with match
      ifc.div_en = 0; ifc.div_val = 8'd0; ifc.cmp_val = 64'h10; ifc.int_en = 1;
      ld = 1; ld_val = 64'd0;
      wait_cyc(cyc + 1);
      ld = 0;
      c0 = cyc;
      ifc.timer_en = 1;
      int_q.push_back(c0 + 18);
      int_q.push_back(c0 + 24);
      wait_cyc(c0 + 17);
      check("count_at_match", cnt, 64'h10);
      check("int_st_before", {63'd0, ifc.int_st}, 64'd0);
      wait_cyc(c0 + 18);
      check("int_st_set", {63'd0, ifc.int_st}, 64'd1);
      check("interrupt_set", {63'd0, ifc.interrupt}, 64'd1);
      wait_cyc(c0 + 19);
      check("count_at_clr", cnt, 64'h12);
      ifc.int_st_clr = 1;
      wait_cyc(c0 + 20);
      ifc.int_st_clr = 0;
      check("int_st_cleared", {63'd0, ifc.int_st}, 64'd0);
      check("interrupt_cleared", {63'd0, ifc.interrupt}, 64'd0);
      ifc.cmp_val = 64'h16;
      wait_cyc(c0 + 23);
      check("count_at_match2", cnt, 64'h16);
      ifc.int_st_clr = 1;
      wait_cyc(c0 + 24);
      ifc.int_st_clr = 0;
      check("set_beats_clear", {63'd0, ifc.int_st}, 64'd1);
      ifc.int_en = 0;
      wait_cyc(c0 + 25);
      check("interrupt_masked", {63'd0, ifc.interrupt}, 64'd0);
      check("int_st_sticky", {63'd0, ifc.int_st}, 64'd1);
      ifc.timer_en = 0;
      wait_cyc(c0 + 27);
      check("t4_int_left", 64'(int_q.size()), 64'd0);

      // wrap through all-ones to 0 with cmp_val = 0
      ifc.int_st_clr = 1; ifc.int_en = 1; ifc.cmp_val = 64'd0;
      ld = 1; ld_val = 64'hFFFF_FFFF_FFFF_FFFE;
      wait_cyc(cyc + 1);
      ifc.int_st_clr = 0; ld = 0;
      check("int_st_idle_clr", {63'd0, ifc.int_st}, 64'd0);
      c0 = cyc;
      ifc.timer_en = 1;
      int_q.push_back(c0 + 4);
      wait_cyc(c0 + 2);
      check("count_all_ones", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_cyc(c0 + 3);
      check("count_wrapped", cnt, 64'd0);
      check("int_st_pre_wrap", {63'd0, ifc.int_st}, 64'd0);
      wait_cyc(c0 + 4);
      check("int_st_wrap", {63'd0, ifc.int_st}, 64'd1);
      check("interrupt_wrap", {63'd0, ifc.interrupt}, 64'd1);

      // reset while halted (or running) with int_st set
      ifc.halt_req = 1;
      wait_cyc(c0 + 5);
`ifdef TIMER_HALT_EN
      check("halt_before_reset", {63'd0, ifc.halt_ack}, 64'd1);
      check("no_tick_in_halt", {63'd0, ifc.count_en}, 64'd0);
`else
      check("run_before_reset", {63'd0, ifc.count_en}, 64'd1);
`endif
      check("int_st_before_reset", {63'd0, ifc.int_st}, 64'd1);
      reset = 1;
      wait_cyc(c0 + 6);
      check("reset_count_en", {63'd0, ifc.count_en}, 64'd0);
      check("reset_halt_ack", {63'd0, ifc.halt_ack}, 64'd0);
      check("reset_int_st", {63'd0, ifc.int_st}, 64'd0);
      check("reset_interrupt", {63'd0, ifc.interrupt}, 64'd0);
      reset = 0; ifc.timer_en = 0; ifc.halt_req = 0;
      wait_cyc(c0 + 8);
      check("t5_int_left", 64'(int_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/timer_cnt_ctrl.md
# timer_cnt_ctrl

Sequencing controller for the 64-bit timer counter datapath. Sits between the register set and the counter. Runs the timer run/halt state machine and the programmable prescaler that produces the single-cycle `count_en` strobe. Compares the live 64-bit count against a compare value to raise a sticky, maskable interrupt.

## Interface
- `DIV_W`, 8, prescaler divisor width; division ratio is `div_val`+1.
- `CNT_W`, 64, counter width; must match the counter datapath.

Ports:
- `clk`  input  1  timer clock; the only clock.
- `reset`  input  1  synchronous, active-high reset.
- `timer_en`  input  1  from regset; 1 = timer running.
- `div_en`  input  1  from regset; 1 = prescaler active, 0 = count every cycle.
- `div_val`  input  DIV_W  from regset; divisor minus one.
- `halt_req`  input  1  debug halt request; level.
- `cmp_val`  input  CNT_W  from regset; compare value.
- `int_en`  input  1  from regset; interrupt mask.
- `int_st_clr`  input  1  from regset; single-cycle write-1-to-clear of `int_st`.
- `count`  input  CNT_W  from counter; current count.
- `count_en`  output  1  to counter; increment strobe.
- `halt_ack`  output  1  debug halt acknowledge.
- `int_st`  output  1  sticky compare-match status.
- `interrupt`  output  1  `int_st & int_en`.

## Operation
- FSM states:
  - IDLE (reset state)
  - RUN
  - HALT
- Transitions, evaluated each `clk` edge:
  - IDLE→RUN: `timer_en`=1.
  - RUN→IDLE: `timer_en`=0.
  - RUN→HALT: `halt_req`=1 and `timer_en`=1.
  - HALT→RUN: `halt_req`=0 and `timer_en`=1.
  - HALT→IDLE: `timer_en`=0. This has priority over the `halt_req` transitions.
- Prescaler `pre_cnt` (DIV_W bits):
  - Held at 0 in IDLE.
  - Frozen in HALT.
  - In RUN with `div_en`=1: `pre_cnt` <= (`pre_cnt`==`div_val`) ? 0 : `pre_cnt`+1.
  - In RUN with `div_en`=0: `pre_cnt` <= 0.
- Divisor change: `div_val` is registered each cycle. If `div_en`=1 and `div_val` ≠ the registered copy, `pre_cnt` <= 0 on that edge. This overrides the increment, so `pre_cnt` never exceeds `div_val`.
- `count_en` is combinational from registered state only: `count_en` = (state==RUN) & (!`div_en` | `pre_cnt`==`div_val`).
  - In IDLE and HALT, `count_en`=0.
- `halt_ack` = (state==HALT).
- Compare:
  - `match` = `timer_en` & (`count`==`cmp_val`). This is a full CNT_W equality, and it also fires for counts loaded by register writes.
  - `int_st` <= `match` ? 1 : (`int_st_clr` ? 0 : `int_st`). Set wins over clear in the same cycle.
  - While halted on a matching count, `int_st` re-sets every cycle. A clear does not stick until `count` or `cmp_val` changes.
- Wrap-around: the counter wraps from all-ones to 0. The controller takes no special action; `cmp_val`=0 matches after wrap.
- `div_val`=0 with `div_en`=1: `count_en` every RUN cycle, identical to `div_en`=0.

## Timing
- Reset values:
  - state=IDLE, `pre_cnt`=0, `int_st`=0.
  - `count_en`=0, `halt_ack`=0, `interrupt`=0.
  - Registered `div_val` copy = 0.
- `timer_en` sampled 1 at edge E: state is RUN after E. With `div_en`=0, `count_en` is high in the following cycle and `count` increments at E+1.
- `div_en`=1, `div_val`=D: first `count_en` in the (D+1)th RUN cycle, then every D+1 cycles.
- `halt_req` sampled 1 at edge E: `count_en`=0 and `halt_ack`=1 from E onward. On release, the prescaler resumes from the frozen `pre_cnt`, with no lost or extra ticks.
- Match: `count` equals `cmp_val` in cycle C, so `int_st` and `interrupt` go high after edge C. Latency is 1 cycle.
- `reset` mid-run: all state returns to reset values at the next edge, regardless of other inputs.

## Configuration
- `TIMER_HALT_EN` defined: debug halt supported as above.
- Not defined:
  - HALT state not built.
  - `halt_req` ignored.
  - `halt_ack` tied to 0.
  - RUN↔IDLE only.

## Structure
- Shared package `timer_pkg` holds:
  - the FSM state type (IDLE/RUN/HALT);
  - the `DIV_W` and `CNT_W` defaults.
- One sub-module, `timer_prescaler`: holds `pre_cnt`, the registered `div_val` copy, change detection and the terminal-count compare. Its inputs are `run`/`freeze` from the FSM, and it outputs the `tick` used for `count_en`.
- FSM and compare/interrupt logic live in `timer_cnt_ctrl`.

## Test plan
- `timer_en`=1, `div_en`=0, counter model attached → `count_en` high every cycle from 1 cycle after enable; count 0→10 in 10 cycles.
- `div_en`=1, `div_val`=3 → `count_en` pulses on RUN cycles 4, 8, 12; change `div_val` to 1 mid-period → next pulse exactly 2 cycles after the change.
- Running with `div_val`=3, `pre_cnt`=2, assert `halt_req` 5 cycles → `halt_ack`=1, `count_en`=0 throughout; after release, next `count_en` 2 cycles later. With `TIMER_HALT_EN` undefined, counting is uninterrupted.
- `cmp_val`=0x10, `int_en`=1 → `int_st`/`interrupt` high the cycle after count=0x10; `int_st_clr` pulse at count=0x12 → cleared; `int_st_clr` coincident with a match → stays 1.
- Counter preloaded to 0xFFFF_FFFF_FFFF_FFFE, `cmp_val`=0 → wraps through all-ones to 0, `int_st` sets 1 cycle after count=0.
- `reset` asserted in HALT with `int_st`=1 → next cycle state IDLE, all outputs 0.
